// File: rtl/music_pkg.sv
// Shared definitions for the music player datapath: divider width, the rest code,
// the default envelope resolution and the tone generator state encoding.
package music_pkg;

    // Width of the sequencer's speaker_divider output.
    parameter int unsigned DIV_WIDTH = 16;

    // Divider value that means "rest": output silent and held low.
    parameter int unsigned REST_DIVIDER = 0;

    // Default envelope / PWM resolution for the optional decay envelope.
    parameter int unsigned ENV_WIDTH = 4;

    // Tone generator operating state, derived from the accepted divider.
    typedef enum logic {
        REST = 1'b0,
        PLAY = 1'b1
    } tone_state_t;

endpackage

// File: rtl/tone_generator_if.sv
// Sequencer-to-tone-generator signal bundle. The master side drives the divider;
// the slave side (the tone generator) returns the speaker pin and status.
interface tone_generator_if #(
    parameter int unsigned DIV_WIDTH = 16
);

    logic [DIV_WIDTH-1:0] divider;      // half-period length in clocks, 0 = rest
    logic                 speaker;      // tone output pin
    logic                 tone_active;  // accepted divider is nonzero
    logic                 period_tick;  // one-cycle pulse per internal toggle

    modport master (
        output divider,
        input  speaker,
        input  tone_active,
        input  period_tick
    );

    modport slave (
        input  divider,
        output speaker,
        output tone_active,
        output period_tick
    );

endinterface

// File: rtl/decay_envelope.sv
// Plucked-note decay envelope: loads full scale on trigger, steps down once every
// DECAY_PERIOD clocks until ENV_FLOOR, and compares it against a free-running PWM
// counter to produce an amplitude gate. Only instantiated with TONE_GEN_DECAY_EN.
module decay_envelope #(
    parameter int unsigned ENV_WIDTH    = music_pkg::ENV_WIDTH,
    parameter int unsigned DECAY_PERIOD = 1000,
    parameter int unsigned ENV_FLOOR    = 0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic trigger_i,  // new nonzero note accepted
    input  logic clear_i,    // note ended, entering rest
    output logic gate_o      // high while the PWM phase is below the envelope
);

    import music_pkg::*;

    localparam int unsigned PreWidth = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;

    localparam logic [ENV_WIDTH-1:0] EnvFull  = {ENV_WIDTH{1'b1}};
    localparam logic [ENV_WIDTH-1:0] EnvFloor = ENV_WIDTH'(ENV_FLOOR);
    localparam logic [PreWidth-1:0]  PreLast  = PreWidth'(DECAY_PERIOD - 1);

    logic [ENV_WIDTH-1:0] env_q, env_d;
    logic [ENV_WIDTH-1:0] pwm_q, pwm_d;
    logic [PreWidth-1:0]  pre_q, pre_d;

    // Envelope level and decay prescaler; a clear wins over a simultaneous trigger.
    always_comb begin
        env_d = env_q;
        pre_d = pre_q;
        pwm_d = pwm_q + 1'b1;
        if (clear_i) begin
            env_d = '0;
            pre_d = '0;
        end else if (trigger_i) begin
            // Restart the prescaler so every note gets a full first step.
            env_d = EnvFull;
            pre_d = '0;
        end else if (pre_q == PreLast) begin
            pre_d = '0;
            if (env_q > EnvFloor) begin
                env_d = env_q - 1'b1;
            end
        end else begin
            pre_d = pre_q + 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            env_q <= '0;
            pre_q <= '0;
            pwm_q <= '0;
        end else begin
            env_q <= env_d;
            pre_q <= pre_d;
            pwm_q <= pwm_d;
        end
    end

    assign gate_o = (pwm_q < env_q);

endmodule

// File: rtl/tone_generator.sv
// Square-wave tone synthesiser fed by the note sequencer's speaker divider.
// The divider is sampled only at half-period boundaries so the output never glitches;
// a zero divider means rest and holds the output low.
// Optional feature: define TONE_GEN_DECAY_EN to add a decay envelope with PWM
// amplitude gating (speaker then gains one register of latency).
module tone_generator #(
`ifdef TONE_GEN_DECAY_EN
    parameter int unsigned ENV_WIDTH    = music_pkg::ENV_WIDTH,
    parameter int unsigned DECAY_PERIOD = 1000,
    parameter int unsigned ENV_FLOOR    = 0,
`endif
    parameter int unsigned DIV_WIDTH    = music_pkg::DIV_WIDTH
) (
    input  logic            clk_i,
    input  logic            rst_i,
    tone_generator_if.slave bus
);

    import music_pkg::*;

    localparam logic [DIV_WIDTH-1:0] RestDiv = DIV_WIDTH'(REST_DIVIDER);

    tone_state_t          state;
    logic [DIV_WIDTH-1:0] divider;
    logic [DIV_WIDTH-1:0] active_div_q, active_div_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic                 square_q, square_d;
    logic                 tick_q, tick_d;

    assign divider = bus.divider;

    // The state is not stored separately: rest is exactly "no divider accepted".
    assign state = (active_div_q == RestDiv) ? REST : PLAY;

    // Next-state logic: accept a note from rest, or count out the half-period and
    // reload the divider only on the boundary cycle.
    always_comb begin
        active_div_d = active_div_q;
        cnt_d        = cnt_q;
        square_d     = square_q;
        tick_d       = 1'b0;
        unique case (state)
            REST: begin
                cnt_d    = '0;
                square_d = 1'b0;
                if (divider != RestDiv) begin
                    // No toggle on entry: first rise comes after a full half-period.
                    active_div_d = divider;
                end
            end
            PLAY: begin
                if (cnt_q == active_div_q - 1'b1) begin
                    cnt_d        = '0;
                    active_div_d = divider;
                    tick_d       = 1'b1;
                    if (divider != RestDiv) begin
                        square_d = ~square_q;
                    end else begin
                        // Ending a note forces the wave low rather than toggling it.
                        square_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                active_div_d = RestDiv;
                cnt_d        = '0;
                square_d     = 1'b0;
            end
        endcase
    end

    // Core registers with synchronous reset back to rest.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active_div_q <= '0;
            cnt_q        <= '0;
            square_q     <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            active_div_q <= active_div_d;
            cnt_q        <= cnt_d;
            square_q     <= square_d;
            tick_q       <= tick_d;
        end
    end

    assign bus.tone_active = (state == PLAY);
    assign bus.period_tick = tick_q;

`ifdef TONE_GEN_DECAY_EN
    logic env_trigger;
    logic env_clear;
    logic env_gate;
    logic speaker_q;

    // A retrigger happens whenever a nonzero divider is loaded that differs from
    // the one already playing; outside boundaries active_div_d equals active_div_q.
    assign env_trigger = (active_div_d != RestDiv) && (active_div_d != active_div_q);
    assign env_clear   = (state == PLAY) && (active_div_d == RestDiv);

    decay_envelope #(
        .ENV_WIDTH    (ENV_WIDTH),
        .DECAY_PERIOD (DECAY_PERIOD),
        .ENV_FLOOR    (ENV_FLOOR)
    ) u_decay_envelope (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .trigger_i (env_trigger),
        .clear_i   (env_clear),
        .gate_o    (env_gate)
    );

    // Amplitude-gated output, registered to keep the pin free of compare glitches.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            speaker_q <= 1'b0;
        end else begin
            speaker_q <= square_q & env_gate;
        end
    end

    assign bus.speaker = speaker_q;
`else
    assign bus.speaker = square_q;
`endif

endmodule

// File: doc/tone_generator.md
# tone_generator

Square-wave tone synthesiser sitting directly downstream of the music player's note sequencer. It consumes the sequencer's 16-bit `speaker_divider` and drives the 1-bit speaker pin. Divider updates are applied only at half-period boundaries, so the output never glitches. A zero divider means rest: the output is silent and held low.

## Interface
- `DIV_WIDTH`, 16: divider width. It matches the sequencer's `speaker_divider` output.
- `ENV_WIDTH`, 4: envelope/PWM resolution (only with `TONE_GEN_DECAY_EN`).
- `DECAY_PERIOD`, 1000: clocks per envelope decrement (only with `TONE_GEN_DECAY_EN`).
- `ENV_FLOOR`, 0: envelope saturation floor (only with `TONE_GEN_DECAY_EN`).
- `clk  in  1`  system clock; all logic on the rising edge.
- `rst  in  1`  synchronous, active-high reset.
- `divider  in  DIV_WIDTH`  half-period length in `clk` cycles; 0 = rest. It may change at any time.
- `speaker  out  1`  tone output.
- `tone_active  out  1`  high while the accepted divider is nonzero.
- `period_tick  out  1`  one-cycle pulse on every internal square toggle.

## Operation
- Registers:
  - `active_div` (accepted divider)
  - `cnt` (DIV_WIDTH half-period counter)
  - `square` (internal wave)
- Two states, derived from `active_div`:
  - `REST` when `active_div == 0`.
  - `PLAY` otherwise.
- REST:
  - `square` is held 0 and `cnt` is held 0.
  - Each cycle `divider` is sampled. If it is nonzero: `active_div <= divider`, `cnt <= 0`, go to PLAY. `square` is not toggled on entry.
- PLAY:
  - `cnt` increments every cycle.
  - When `cnt == active_div-1`: `cnt <= 0`, `active_div <= divider` (shadow load), and `period_tick` pulses.
  - At that boundary, if the new `divider` is nonzero, `square <= ~square`. If it is 0, `square <= 0` (forced low, not toggled) and the block goes to REST.
- `divider` changes within a half-period are ignored; only the value present at the boundary cycle is taken.
- Divider 1 is legal: `square` toggles every cycle.
- `tone_active = (active_div != 0)`, combinational from the register.
- Without `TONE_GEN_DECAY_EN`: `speaker = square`.

## Timing
- Reset values:
  - `active_div` = 0, `cnt` = 0, `square` = 0.
  - `speaker` = 0, `tone_active` = 0, `period_tick` = 0.
  - Envelope = 0, PWM counter = 0.
- Reset asserted mid-tone: next edge returns to REST with the output low.
- From REST, with a nonzero divider D applied in cycle 0:
  - `tone_active` rises in cycle 1.
  - First `square` rise at the edge ending cycle D.
  - Thereafter the output toggles every D cycles (full period 2·D).
- Divider change while playing takes effect at the next boundary. The current half-period always completes at the old length.
- `period_tick` is registered: it is high in the cycle after the boundary edge. It does not pulse on REST entry from REST.
- Counter arithmetic is unsigned DIV_WIDTH. `cnt` never exceeds `active_div-1`, so there is no wrap.

## Configuration
- `TONE_GEN_DECAY_EN` defined: adds a plucked-note decay envelope.
  - `env` (ENV_WIDTH) is loaded with all-ones whenever a nonzero divider is accepted that differs from the previous `active_div` (including REST→PLAY).
  - `env` decrements once per `DECAY_PERIOD` clocks, saturating at `ENV_FLOOR`.
  - A free-running ENV_WIDTH PWM counter gates the output: `speaker <= square & (pwm_cnt < env)`. `speaker` is registered, adding one cycle of latency.
  - `env` is cleared on REST entry.
- Macro undefined: no envelope or PWM logic is synthesised, and `speaker` is `square` directly.

## Structure
- Shared package `music_pkg`:
  - `DIV_WIDTH`
  - `REST_DIVIDER` = 0
  - default `ENV_WIDTH`
  - an enum `tone_state_t {REST, PLAY}`
- Sub-module `decay_envelope` holds `env`, the decay prescaler and the PWM counter. Its ports:
  - inputs `trigger` and `clear`
  - output `gate`
- It is instantiated only under `TONE_GEN_DECAY_EN`.

## Test plan
- Reset then divider=4 held → `tone_active` high at cycle 1; `speaker` rises after cycle 4 edge, falls after cycle 8, period 8, 50% duty; `period_tick` every 4 cycles.
- Divider changed 4→6 two cycles into a half-period → current half-period still 4 cycles; subsequent half-periods 6 cycles; no short pulse.
- Playing divider=3, divider set to 0 while `square` high → `speaker` low at next boundary; `tone_active` falls; stays low 50 cycles.
- Divider=1 → `speaker` toggles every cycle; divider pulses 5→9→5 within one half-period of 10 → only the boundary value is used.
- Synchronous `rst` asserted mid-tone for 1 cycle → all outputs 0 next cycle; restart with divider=2 matches the REST→PLAY timing.
- With `TONE_GEN_DECAY_EN`, DECAY_PERIOD=4, divider=8 → PWM duty of `speaker`-high windows falls 15/16→14/16… every 4 clocks; retriggers to 15 on change to divider=5; same divider reapplied does not retrigger.
